// File: rtl/fw_rule_writer.sv
// Packs 16-bit blocked-port rules four per 72-bit SRAM word and writes them over wr_0.
// Read-back verify over rd_0 is present only when FW_RULE_WRITER_VERIFY_EN is defined.
module fw_rule_writer #(
  parameter int SRAM_ADDR_WIDTH = 19,
  parameter int SRAM_DATA_WIDTH = 72,
  parameter int SLOT_WIDTH      = 18,
  parameter int BASE_ADDR       = 0,
  parameter int NUM_WORDS       = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rule_valid,
  input  logic [15:0]                rule_port,
  output logic                       rule_ready,
  input  logic                       flush,
  input  logic                       clear,
  output logic                       wr_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_0_data,
  input  logic                       wr_0_ack,
  output logic                       rd_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_0_data,
  input  logic                       rd_0_ack,
  input  logic                       rd_0_vld,
  output logic                       busy,
  output logic [15:0]                words_written,
  output logic                       verify_err
);
  typedef enum logic [2:0] {IDLE, WRITE, VRD_REQ, VRD_WAIT, CLEAR} state_t;

  localparam logic [SRAM_ADDR_WIDTH-1:0] FIRST    = SRAM_ADDR_WIDTH'(BASE_ADDR);
  localparam logic [SRAM_ADDR_WIDTH-1:0] LAST     = SRAM_ADDR_WIDTH'(BASE_ADDR + NUM_WORDS - 1);
  localparam logic [SRAM_DATA_WIDTH-1:0] ALL_ONES = '1;

  state_t                     state;
  logic [1:0]                 slot_cnt;
  logic [SRAM_DATA_WIDTH-1:0] word;
  logic [SRAM_DATA_WIDTH-1:0] next_word;
  logic [SRAM_ADDR_WIDTH-1:0] ptr;
  logic [SRAM_ADDR_WIDTH-1:0] ptr_inc;
  logic                       clear_pend;
  logic                       clear_go;
  logic                       accept;
  logic                       launch;

  assign clear_go   = clear || clear_pend;
  assign rule_ready = reset && (state == IDLE) && !clear_go;
  assign accept     = rule_valid && rule_ready;
  assign launch     = (accept && slot_cnt == 2'd3) ||
                      (rule_ready && flush && (accept || slot_cnt != 2'd0));
  assign ptr_inc    = (ptr == LAST) ? FIRST : ptr + SRAM_ADDR_WIDTH'(1);

  // The staging word idles at all-ones, so unfilled slots are already padded on flush.
  always_comb begin
    next_word = word;
    for (int i = 0; i < 4; i++) begin
      if (accept && slot_cnt == i[1:0]) begin
        next_word[i*SLOT_WIDTH +: SLOT_WIDTH] = SLOT_WIDTH'(rule_port);
      end
    end
  end

`ifndef FW_RULE_WRITER_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^{rd_0_data, rd_0_ack, rd_0_vld};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      slot_cnt      <= '0;
      word          <= ALL_ONES;
      ptr           <= FIRST;
      clear_pend    <= 1'b0;
      wr_0_req      <= 1'b0;
      wr_0_addr     <= FIRST;
      wr_0_data     <= '0;
      rd_0_req      <= 1'b0;
      rd_0_addr     <= FIRST;
      busy          <= 1'b0;
      words_written <= '0;
      verify_err    <= 1'b0;
    end else begin
      // A clear seen while busy is remembered and honoured on the next return to IDLE.
      if (clear) clear_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clear_go) begin
            state      <= CLEAR;
            busy       <= 1'b1;
            clear_pend <= 1'b0;
            slot_cnt   <= '0;
            word       <= ALL_ONES;
            ptr        <= FIRST;
            wr_0_req   <= 1'b1;
            wr_0_addr  <= FIRST;
            wr_0_data  <= ALL_ONES;
          end else if (launch) begin
            state     <= WRITE;
            busy      <= 1'b1;
            slot_cnt  <= '0;
            word      <= ALL_ONES;
            wr_0_req  <= 1'b1;
            wr_0_addr <= ptr;
            wr_0_data <= next_word;
          end else if (accept) begin
            word     <= next_word;
            slot_cnt <= slot_cnt + 2'd1;
          end
        end
        WRITE: begin
          if (wr_0_ack) begin
            wr_0_req <= 1'b0;
            ptr      <= ptr_inc;
            if (words_written != 16'hFFFF) words_written <= words_written + 16'd1;
`ifdef FW_RULE_WRITER_VERIFY_EN
            state     <= VRD_REQ;
            rd_0_req  <= 1'b1;
            rd_0_addr <= wr_0_addr;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end
`ifdef FW_RULE_WRITER_VERIFY_EN
        VRD_REQ: begin
          if (rd_0_ack) begin
            rd_0_req <= 1'b0;
            state    <= VRD_WAIT;
          end
        end
        VRD_WAIT: begin
          if (rd_0_vld) begin
            if (rd_0_data != wr_0_data) verify_err <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        CLEAR: begin
          if (wr_0_ack) begin
            if (ptr == LAST) begin
              state         <= IDLE;
              busy          <= 1'b0;
              wr_0_req      <= 1'b0;
              ptr           <= FIRST;
              words_written <= '0;
              verify_err    <= 1'b0;
            end else begin
              ptr       <= ptr_inc;
              wr_0_addr <= ptr_inc;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fw_rule_writer.sv
// Directed bench for fw_rule_writer with a two-word table: vector table of rule words
// followed by hand sequences for flush-empty, clear, reset mid-write and read-back verify.
module tb_fw_rule_writer;
  localparam int AW = 19;
  localparam int DW = 72;
  localparam logic [DW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rule_valid = 1'b0;
  logic [15:0]   rule_port = '0;
  logic          flush = 1'b0;
  logic          clear = 1'b0;
  logic          wr_0_ack = 1'b0;
  logic [DW-1:0] rd_0_data = '0;
  logic          rd_0_ack = 1'b0;
  logic          rd_0_vld = 1'b0;
  logic          rule_ready, wr_0_req, rd_0_req, busy, verify_err;
  logic [AW-1:0] wr_0_addr, rd_0_addr;
  logic [DW-1:0] wr_0_data;
  logic [15:0]   words_written;

  int total = 0;
  int bad = 0;
`ifdef FW_RULE_WRITER_VERIFY_EN
  bit corrupt_next = 1'b0;
  bit verr_exp = 1'b0;
`endif

  fw_rule_writer #(.NUM_WORDS(2)) dut (
    .clk(clk), .reset(reset), .rule_valid(rule_valid), .rule_port(rule_port),
    .rule_ready(rule_ready), .flush(flush), .clear(clear),
    .wr_0_req(wr_0_req), .wr_0_addr(wr_0_addr), .wr_0_data(wr_0_data), .wr_0_ack(wr_0_ack),
    .rd_0_req(rd_0_req), .rd_0_addr(rd_0_addr), .rd_0_data(rd_0_data), .rd_0_ack(rd_0_ack),
    .rd_0_vld(rd_0_vld), .busy(busy), .words_written(words_written), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              n;
    logic [3:0][15:0] p;
    bit              fl;
    int              dly;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   data;
  } vec_t;

  vec_t vt[6];

  function automatic vec_t mk(input int n, input logic [3:0][15:0] p, input bit fl,
                              input int dly, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    vec_t v;
    v.n = n; v.p = p; v.fl = fl; v.dly = dly; v.addr = addr; v.data = data;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rules(input string nm, input int n, input logic [3:0][15:0] p, input bit fl);
    for (int i = 0; i < n; i++) begin
      rule_valid = 1'b1;
      rule_port  = p[i];
      flush      = fl && (i == n - 1);
      #1;
      chk({nm, " ready"}, rule_ready, 1);
      @(posedge clk);
      #1;
    end
    rule_valid = 1'b0;
    flush      = 1'b0;
  endtask

  // Entered one step after the launching accept; leaves one step after the writer is idle.
  task automatic do_write(input string nm, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int dly);
    chk({nm, " req"}, wr_0_req, 1);
    chk({nm, " addr"}, wr_0_addr, addr);
    chk({nm, " data"}, wr_0_data, data);
    chk({nm, " busy"}, busy, 1);
    chk({nm, " ready low"}, rule_ready, 0);
    for (int d = 0; d < dly; d++) begin
      step();
      chk({nm, " hold"}, {wr_0_req, wr_0_addr, wr_0_data}, {1'b1, addr, data});
      chk({nm, " ready held low"}, rule_ready, 0);
    end
    wr_0_ack = 1'b1;
    step();
    wr_0_ack = 1'b0;
    chk({nm, " req drop"}, wr_0_req, 0);
`ifdef FW_RULE_WRITER_VERIFY_EN
    chk({nm, " rd req"}, rd_0_req, 1);
    chk({nm, " rd addr"}, rd_0_addr, addr);
    rd_0_ack = 1'b1;
    step();
    rd_0_ack = 1'b0;
    chk({nm, " rd req drop"}, rd_0_req, 0);
    chk({nm, " ready during verify"}, rule_ready, 0);
    rd_0_vld  = 1'b1;
    rd_0_data = corrupt_next ? (data ^ 72'h20) : data;
    step();
    rd_0_vld = 1'b0;
    if (corrupt_next) verr_exp = 1'b1;
    chk({nm, " verify_err"}, verify_err, verr_exp);
`else
    chk({nm, " rd req idle"}, rd_0_req, 0);
    chk({nm, " verify_err"}, verify_err, 0);
`endif
    chk({nm, " ready back"}, rule_ready, 1);
    chk({nm, " busy drop"}, busy, 0);
  endtask

  initial begin
    vt[0] = mk(4, {16'd22, 16'd1010, 16'd443, 16'd80}, 1'b0, 2, 19'd0,
               {18'h00016, 18'h003F2, 18'h001BB, 18'h00050});
    vt[1] = mk(1, {16'd0, 16'd0, 16'd0, 16'd1020}, 1'b1, 1, 19'd1,
               {18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h003FC});
    vt[2] = mk(4, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 0, 19'd0,
               {18'h00004, 18'h00003, 18'h00002, 18'h00001});
    vt[3] = mk(2, {16'd0, 16'd0, 16'd0, 16'hFFFF}, 1'b1, 1, 19'd1,
               {18'h3FFFF, 18'h3FFFF, 18'h00000, 18'h0FFFF});
    vt[4] = mk(3, {16'd0, 16'd9, 16'd8, 16'd7}, 1'b1, 3, 19'd0,
               {18'h3FFFF, 18'h00009, 18'h00008, 18'h00007});
    vt[5] = mk(4, {16'd44, 16'd33, 16'd22, 16'd11}, 1'b1, 0, 19'd1,
               {18'h0002C, 18'h00021, 18'h00016, 18'h0000B});

    // Reset values, with a rule offered so rule_ready must be gated by reset.
    rule_valid = 1'b1;
    repeat (3) step();
    chk("rst rule_ready", rule_ready, 0);
    chk("rst wr_req", wr_0_req, 0);
    chk("rst rd_req", rd_0_req, 0);
    chk("rst busy", busy, 0);
    chk("rst verify_err", verify_err, 0);
    chk("rst wr_addr", wr_0_addr, 0);
    chk("rst rd_addr", rd_0_addr, 0);
    chk("rst wr_data", wr_0_data, 0);
    chk("rst words", words_written, 0);
    rule_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("idle ready", rule_ready, 1);

    // Flush with no pending rules must not start a write.
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("empty flush no req", wr_0_req, 0);
      chk("empty flush not busy", busy, 0);
      step();
    end

    for (int i = 0; i < 6; i++) begin
      send_rules($sformatf("vec%0d", i), vt[i].n, vt[i].p, vt[i].fl);
      do_write($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].dly);
      chk($sformatf("vec%0d words", i), words_written, 96'(i + 1));
    end

`ifdef FW_RULE_WRITER_VERIFY_EN
    corrupt_next = 1'b1;
    send_rules("vbad", 4, {16'd4, 16'd3, 16'd2, 16'd1}, 1'b0);
    do_write("vbad", 19'd0, {18'h00004, 18'h00003, 18'h00002, 18'h00001}, 1);
    corrupt_next = 1'b0;
    send_rules("vgood", 1, {16'd0, 16'd0, 16'd0, 16'd1020}, 1'b1);
    do_write("vgood", 19'd1, {18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h003FC}, 0);
    chk("verify_err sticky", verify_err, 1);
    verr_exp = 1'b0;
`endif

    // Clear with a rule offered in the same cycle: rule refused, partial word dropped.
    send_rules("pre clear", 2, {16'd0, 16'd0, 16'd200, 16'd100}, 1'b0);
    rule_valid = 1'b1;
    rule_port  = 16'd300;
    clear      = 1'b1;
    #1;
    chk("clear blocks ready", rule_ready, 0);
    @(posedge clk);
    #1;
    rule_valid = 1'b0;
    clear      = 1'b0;
    chk("clr0 req", wr_0_req, 1);
    chk("clr0 addr", wr_0_addr, 0);
    chk("clr0 data", wr_0_data, ONES);
    chk("clr busy", busy, 1);
    wr_0_ack = 1'b1;
    step();
    chk("clr1 req", wr_0_req, 1);
    chk("clr1 addr", wr_0_addr, 1);
    chk("clr1 data", wr_0_data, ONES);
    step();
    wr_0_ack = 1'b0;
    chk("clr done req", wr_0_req, 0);
    chk("clr words", words_written, 0);
    chk("clr verify_err", verify_err, 0);
    chk("clr busy drop", busy, 0);
    chk("clr ready", rule_ready, 1);
    send_rules("post clear", 4, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b0);
    do_write("post clear", 19'd0, {18'h00008, 18'h00007, 18'h00006, 18'h00005}, 1);
    chk("post clear words", words_written, 1);

    // Reset while a write is outstanding.
    send_rules("pre rst", 4, {16'd14, 16'd13, 16'd12, 16'd11}, 1'b0);
    chk("pre rst req", wr_0_req, 1);
    chk("pre rst addr", wr_0_addr, 1);
    reset = 1'b0;
    step();
    chk("mid rst req", wr_0_req, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst ready", rule_ready, 0);
    chk("mid rst words", words_written, 0);
    reset = 1'b1;
    step();
    send_rules("post rst", 4, {16'd24, 16'd23, 16'd22, 16'd21}, 1'b0);
    do_write("post rst", 19'd0, {18'h00018, 18'h00017, 18'h00016, 18'h00015}, 1);
    chk("post rst words", words_written, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fw_rule_writer.md
# fw_rule_writer

SRAM rule-table writer for the mini firewall. Accepts destination-port rules one at a time, packs four 18-bit slots into one 72-bit SRAM word, and writes it through the `wr_0` SRAM port. This is the word format the firewall's port check reads back over `rd_0`. It sits beside the firewall in the user data path and is fed by the software-register block.

## Interface
Parameters:
- SRAM_ADDR_WIDTH, 19, SRAM word address width
- SRAM_DATA_WIDTH, 72, SRAM word width (4 × SLOT_WIDTH)
- SLOT_WIDTH, 18, width of one rule slot
- BASE_ADDR, 0, first rule-table word address
- NUM_WORDS, 1, number of rule-table words (≥1)

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-low reset
- rule_valid  in  1  rule offered
- rule_port  in  16  destination port to block
- rule_ready  out  1  rule accepted when rule_valid && rule_ready
- flush  in  1  pulse; write the partially filled word
- clear  in  1  pulse; erase the whole table
- wr_0_req  out  1  SRAM write request
- wr_0_addr  out  SRAM_ADDR_WIDTH  write address
- wr_0_data  out  SRAM_DATA_WIDTH  write data
- wr_0_ack  in  1  write accepted
- rd_0_req  out  1  SRAM read request (verify only)
- rd_0_addr  out  SRAM_ADDR_WIDTH  read address
- rd_0_data  in  SRAM_DATA_WIDTH  read data
- rd_0_ack  in  1  read request accepted
- rd_0_vld  in  1  rd_0_data valid
- busy  out  1  state ≠ IDLE
- words_written  out  16  completed writes, saturating
- verify_err  out  1  sticky readback mismatch

## Operation
- Slot encoding:
  - Rule slot = {2'b00, rule_port}.
  - Empty slot = 18'h3FFFF. The upper bits are nonzero, so an empty slot never matches a zero-extended 16-bit port.
- Fill order: slot 0 = [17:0], slot 1 = [35:18], slot 2 = [53:36], slot 3 = [71:54]. slot_cnt is 2 bits.
- States: IDLE, WRITE, VRD_REQ, VRD_WAIT, CLEAR.
- IDLE:
  - rule_ready = !clear.
  - Accepting a rule stores it in slot slot_cnt and increments slot_cnt.
  - Accepting the 4th rule goes to WRITE.
- flush in IDLE:
  - With slot_cnt > 0: pad the remaining slots with 18'h3FFFF and go to WRITE.
  - With slot_cnt == 0: ignored.
  - flush in the same cycle as a rule accept: the rule is included first.
- clear: has priority over rule_valid and flush in IDLE. It discards any partial word and goes to CLEAR.
- clear outside IDLE: latched, and honoured when the state next returns to IDLE.
- WRITE:
  - wr_0_req = 1, with addr = ptr and data = packed word, all held stable until wr_0_ack is sampled high.
  - On ack: ptr advances, wrapping from BASE_ADDR+NUM_WORDS-1 to BASE_ADDR. words_written increments, saturating at 16'hFFFF. slot_cnt clears.
  - Next state is VRD_REQ if verify is compiled in, else IDLE.
- VRD_REQ: rd_0_req = 1 and rd_0_addr = the just-written address, held until rd_0_ack; then VRD_WAIT.
- VRD_WAIT: on rd_0_vld, compare rd_0_data with the written word. A mismatch sets verify_err. Then IDLE.
- CLEAR:
  - Writes 72'hFF_FFFF_FFFF_FFFF_FFFF to BASE_ADDR..BASE_ADDR+NUM_WORDS-1 using the WRITE handshake, without verify.
  - Then ptr = BASE_ADDR, words_written = 0, verify_err = 0, and back to IDLE.
- Reset mid-operation: abandons everything. Any pending request drops the next cycle; the partial word is lost.

## Timing
- Reset values:
  - rule_ready = 0 while reset is low.
  - wr_0_req, rd_0_req, busy, verify_err = 0.
  - wr_0_addr, rd_0_addr = BASE_ADDR; wr_0_data = 0; words_written = 0.
  - State = IDLE, ptr = BASE_ADDR, slot_cnt = 0.
- 4th rule accepted, or flush, at cycle N: wr_0_req = 1 at N+1.
- wr_0_ack sampled high at cycle M: wr_0_req = 0 at M+1.
  - Without verify: rule_ready = 1 at M+1.
  - With verify: rd_0_req = 1 at M+1.
- rd_0_vld at cycle V: verify_err updates at V+1, and rule_ready = 1 at V+1.
- wr_0_ack arriving in the same cycle wr_0_req first rises is valid: one-cycle write.
- All outputs are registered except rule_ready.

## Configuration
- FW_RULE_WRITER_VERIFY_EN defined: VRD_REQ/VRD_WAIT are present and every rule-word write is read back and compared.
- Not defined:
  - WRITE returns directly to IDLE.
  - rd_0_req is held at 0 and rd_0_addr at BASE_ADDR.
  - verify_err is held at 0.
  - rd_0_* inputs are ignored.

## Test plan
- Rules 80, 443, 1010, 22 back to back, ack after 2 cycles:
  - one write to addr 0 of 72'h{00016, 003F2, 001BB, 00050};
  - words_written = 1.
- Rule 1020 then flush:
  - write data = {3FFFF, 3FFFF, 3FFFF, 003FC};
  - flush with no pending rules issues no write.
- NUM_WORDS = 2, 12 rules:
  - writes go to addr 0, 1, 0 (wrap);
  - rule_ready stays low from the 4th accept until ack+1.
- Two rules, then clear asserted together with rule_valid:
  - the rule is not accepted;
  - all-ones words are written to every table address;
  - words_written = 0.
- VERIFY_EN, readback with bit 5 flipped:
  - verify_err = 1 one cycle after rd_0_vld and stays set until clear.
- reset low while wr_0_req is high:
  - wr_0_req = 0 next cycle;
  - after release, 4 new rules write to BASE_ADDR.
